dram_ddr_pad_rptr_pipe: RTL and testbench

//  Parametrised, pipelined repeater between the DRAM controller and the DDR pad ring.

---
 rtl/dram_ddr_pad_rptr_pipe.sv | 192 +++++++++++++++++++
 tb/tb_dram_ddr_pad_rptr_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_ddr_pad_rptr_pipe.sv
// Pipelined repeater between the DRAM controller and the DDR pad ring.
// Outbound command/data and inbound read data each cross a configurable number of flop stages.
module dram_ddr_pad_rptr_pipe #(
    parameter int OUT_STAGES = 2,
    parameter int IN_STAGES  = 2,
    parameter int ADDR_W     = 15,
    parameter int BANK_W     = 3,
    parameter int CS_W       = 4,
    parameter int DOUT_W     = 288,
    parameter int DIN_W      = 256,
    parameter int ECC_W      = 32,
    parameter int PTR_W      = 5,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              arst_l,
    input  logic              dram_io_ras_l,
    input  logic              dram_io_cas_l,
    input  logic              dram_io_write_en_l,
    input  logic [CS_W-1:0]   dram_io_cs_l,
    input  logic [ADDR_W-1:0] dram_io_addr,
    input  logic [BANK_W-1:0] dram_io_bank,
    input  logic              dram_io_cke,
    input  logic              dram_io_clk_enable,
    input  logic              dram_io_pad_enable,
    input  logic              dram_io_drive_data,
    input  logic              dram_io_drive_enable,
    input  logic              dram_io_pad_clk_inv,
    input  logic [PTR_W-1:0]  dram_io_ptr_clk_inv,
    input  logic              dram_io_channel_disabled,
    input  logic [DOUT_W-1:0] dram_io_data_out,
    input  logic              io_dram_data_valid,
    input  logic [DIN_W-1:0]  io_dram_data_in,
    input  logic [ECC_W-1:0]  io_dram_ecc_in,
    output logic              dram_io_ras_l_buf,
    output logic              dram_io_cas_l_buf,
    output logic              dram_io_write_en_l_buf,
    output logic [CS_W-1:0]   dram_io_cs_l_buf,
    output logic [ADDR_W-1:0] dram_io_addr_buf,
    output logic [BANK_W-1:0] dram_io_bank_buf,
    output logic              dram_io_cke_buf,
    output logic              dram_io_clk_enable_buf,
    output logic              dram_io_pad_enable_buf,
    output logic              dram_io_drive_data_buf,
    output logic              dram_io_drive_enable_buf,
    output logic              dram_io_pad_clk_inv_buf,
    output logic [PTR_W-1:0]  dram_io_ptr_clk_inv_buf,
    output logic              dram_io_channel_disabled_buf,
    output logic [DOUT_W-1:0] dram_io_data_out_buf,
    output logic              io_dram_data_valid_buf,
    output logic [DIN_W-1:0]  io_dram_data_in_buf,
    output logic [ECC_W-1:0]  io_dram_ecc_in_buf,
    output logic [CNT_W-1:0]  rptr_beat_cnt
);

    typedef struct packed {
        logic              ras_l;
        logic              cas_l;
        logic              write_en_l;
        logic [CS_W-1:0]   cs_l;
        logic              cke;
        logic              clk_enable;
        logic              pad_enable;
        logic              drive_data;
        logic              drive_enable;
        logic              pad_clk_inv;
        logic [PTR_W-1:0]  ptr_clk_inv;
        logic              channel_disabled;
    } ctl_t;

    localparam ctl_t CTL_RST = '{ras_l: 1'b1, cas_l: 1'b1, write_en_l: 1'b1, cs_l: '1,
                                 cke: 1'b0, clk_enable: 1'b0, pad_enable: 1'b0,
                                 drive_data: 1'b0, drive_enable: 1'b0, pad_clk_inv: 1'b0,
                                 ptr_clk_inv: '0, channel_disabled: 1'b1};

    // A disabled channel issues deselect/NOP and releases the DQ drivers.
    function automatic ctl_t gate_cmd(input ctl_t c);
        ctl_t g;
        g = c;
        if (c.channel_disabled) begin
            g.ras_l        = 1'b1;
            g.cas_l        = 1'b1;
            g.write_en_l   = 1'b1;
            g.cs_l         = '1;
            g.drive_data   = 1'b0;
            g.drive_enable = 1'b0;
        end
        return g;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    ctl_t              ctl_in;
    ctl_t              ctl_p  [OUT_STAGES];
    logic [ADDR_W-1:0] addr_p [OUT_STAGES];
    logic [BANK_W-1:0] bank_p [OUT_STAGES];
    logic [DOUT_W-1:0] dout_p [OUT_STAGES];
    logic              vld_p  [IN_STAGES];
    logic [DIN_W-1:0]  din_p  [IN_STAGES];
    logic [ECC_W-1:0]  ecc_p  [IN_STAGES];
    logic [CNT_W-1:0]  cnt_q;

    assign ctl_in = '{ras_l: dram_io_ras_l, cas_l: dram_io_cas_l, write_en_l: dram_io_write_en_l,
                      cs_l: dram_io_cs_l, cke: dram_io_cke, clk_enable: dram_io_clk_enable,
                      pad_enable: dram_io_pad_enable, drive_data: dram_io_drive_data,
                      drive_enable: dram_io_drive_enable, pad_clk_inv: dram_io_pad_clk_inv,
                      ptr_clk_inv: dram_io_ptr_clk_inv,
                      channel_disabled: dram_io_channel_disabled};

    // Outbound stage 0 gates on the capturing cycle's own disable; later stages shift.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            for (int k = 0; k < OUT_STAGES; k++) begin
                ctl_p[k]  <= CTL_RST;
                addr_p[k] <= '0;
                bank_p[k] <= '0;
                dout_p[k] <= '0;
            end
        end else begin
            ctl_p[0] <= gate_cmd(ctl_in);
            if (!dram_io_channel_disabled) begin
                addr_p[0] <= dram_io_addr;
                bank_p[0] <= dram_io_bank;
                dout_p[0] <= dram_io_data_out;
            end
            for (int k = 1; k < OUT_STAGES; k++) begin
                ctl_p[k]  <= ctl_p[k-1];
                addr_p[k] <= addr_p[k-1];
                bank_p[k] <= bank_p[k-1];
                dout_p[k] <= dout_p[k-1];
            end
        end
    end

    // Inbound stages: valid always shifts, data only follows a valid beat.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            for (int k = 0; k < IN_STAGES; k++) begin
                vld_p[k] <= 1'b0;
                din_p[k] <= '0;
                ecc_p[k] <= '0;
            end
        end else begin
            vld_p[0] <= io_dram_data_valid;
            if (io_dram_data_valid) begin
                din_p[0] <= io_dram_data_in;
                ecc_p[0] <= io_dram_ecc_in;
            end
            for (int k = 1; k < IN_STAGES; k++) begin
                vld_p[k] <= vld_p[k-1];
                if (vld_p[k-1]) begin
                    din_p[k] <= din_p[k-1];
                    ecc_p[k] <= ecc_p[k-1];
                end
            end
        end
    end

    // Debug beat counter, observed at the repeated outputs.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            cnt_q <= '0;
        end else if (ctl_p[OUT_STAGES-1].channel_disabled) begin
            cnt_q <= '0;
        end else if (vld_p[IN_STAGES-1]) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign dram_io_ras_l_buf            = ctl_p[OUT_STAGES-1].ras_l;
    assign dram_io_cas_l_buf            = ctl_p[OUT_STAGES-1].cas_l;
    assign dram_io_write_en_l_buf       = ctl_p[OUT_STAGES-1].write_en_l;
    assign dram_io_cs_l_buf             = ctl_p[OUT_STAGES-1].cs_l;
    assign dram_io_cke_buf              = ctl_p[OUT_STAGES-1].cke;
    assign dram_io_clk_enable_buf       = ctl_p[OUT_STAGES-1].clk_enable;
    assign dram_io_pad_enable_buf       = ctl_p[OUT_STAGES-1].pad_enable;
    assign dram_io_drive_data_buf       = ctl_p[OUT_STAGES-1].drive_data;
    assign dram_io_drive_enable_buf     = ctl_p[OUT_STAGES-1].drive_enable;
    assign dram_io_pad_clk_inv_buf      = ctl_p[OUT_STAGES-1].pad_clk_inv;
    assign dram_io_ptr_clk_inv_buf      = ctl_p[OUT_STAGES-1].ptr_clk_inv;
    assign dram_io_channel_disabled_buf = ctl_p[OUT_STAGES-1].channel_disabled;
    assign dram_io_addr_buf             = addr_p[OUT_STAGES-1];
    assign dram_io_bank_buf             = bank_p[OUT_STAGES-1];
    assign dram_io_data_out_buf         = dout_p[OUT_STAGES-1];
    assign io_dram_data_valid_buf       = vld_p[IN_STAGES-1];
    assign io_dram_data_in_buf          = din_p[IN_STAGES-1];
    assign io_dram_ecc_in_buf           = ecc_p[IN_STAGES-1];
    assign rptr_beat_cnt                = cnt_q;

endmodule

// File: tb/tb_dram_ddr_pad_rptr_pipe.sv
// Bench for dram_ddr_pad_rptr_pipe: three parameterisations share one stimulus stream and
// are compared each cycle against a history-based model of the repeater.
module tb_dram_ddr_pad_rptr_pipe;

    localparam int NI = 3;
    localparam int OSA [NI] = '{3, 1, 4};
    localparam int ISA [NI] = '{2, 1, 4};
    localparam int CWA [NI] = '{4, 16, 16};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arst_l;
    logic ras_l, cas_l, we_l, cke, clk_en, pad_en, drv_data, drv_en, pad_inv, dis, dv;
    logic [3:0]   cs_l;
    logic [14:0]  addr;
    logic [2:0]   bank;
    logic [4:0]   ptr_inv;
    logic [287:0] dout;
    logic [255:0] din;
    logic [31:0]  ecc;

    logic         ras_b [NI], cas_b [NI], we_b [NI], cke_b [NI], clken_b [NI], paden_b [NI];
    logic         dd_b [NI], de_b [NI], padinv_b [NI], dis_b [NI], vld_b [NI];
    logic [3:0]   cs_b [NI];
    logic [14:0]  addr_b [NI];
    logic [2:0]   bank_b [NI];
    logic [4:0]   ptrinv_b [NI];
    logic [287:0] dout_b [NI];
    logic [255:0] din_b [NI];
    logic [31:0]  ecc_b [NI];
    logic [15:0]  cnt_b [NI];

    for (genvar g = 0; g < NI; g++) begin : gi
        logic [CWA[g]-1:0] c;
        dram_ddr_pad_rptr_pipe #(.OUT_STAGES(OSA[g]), .IN_STAGES(ISA[g]), .CNT_W(CWA[g])) dut (
            .clk(clk), .arst_l(arst_l),
            .dram_io_ras_l(ras_l), .dram_io_cas_l(cas_l), .dram_io_write_en_l(we_l),
            .dram_io_cs_l(cs_l), .dram_io_addr(addr), .dram_io_bank(bank),
            .dram_io_cke(cke), .dram_io_clk_enable(clk_en), .dram_io_pad_enable(pad_en),
            .dram_io_drive_data(drv_data), .dram_io_drive_enable(drv_en),
            .dram_io_pad_clk_inv(pad_inv), .dram_io_ptr_clk_inv(ptr_inv),
            .dram_io_channel_disabled(dis), .dram_io_data_out(dout),
            .io_dram_data_valid(dv), .io_dram_data_in(din), .io_dram_ecc_in(ecc),
            .dram_io_ras_l_buf(ras_b[g]), .dram_io_cas_l_buf(cas_b[g]),
            .dram_io_write_en_l_buf(we_b[g]), .dram_io_cs_l_buf(cs_b[g]),
            .dram_io_addr_buf(addr_b[g]), .dram_io_bank_buf(bank_b[g]),
            .dram_io_cke_buf(cke_b[g]), .dram_io_clk_enable_buf(clken_b[g]),
            .dram_io_pad_enable_buf(paden_b[g]), .dram_io_drive_data_buf(dd_b[g]),
            .dram_io_drive_enable_buf(de_b[g]), .dram_io_pad_clk_inv_buf(padinv_b[g]),
            .dram_io_ptr_clk_inv_buf(ptrinv_b[g]), .dram_io_channel_disabled_buf(dis_b[g]),
            .dram_io_data_out_buf(dout_b[g]), .io_dram_data_valid_buf(vld_b[g]),
            .io_dram_data_in_buf(din_b[g]), .io_dram_ecc_in_buf(ecc_b[g]),
            .rptr_beat_cnt(c));
        assign cnt_b[g] = 16'(c);
    end

    typedef struct {
        logic ras_l, cas_l, we_l, cke, clk_en, pad_en, drv_data, drv_en, pad_inv, dis, dv;
        logic [3:0]   cs_l;
        logic [14:0]  addr;
        logic [2:0]   bank;
        logic [4:0]   ptr_inv;
        logic [287:0] dout;
        logic [255:0] din;
        logic [31:0]  ecc;
    } stim_t;

    // Inputs captured at each clock edge since the last reset; index 0 is the oldest.
    stim_t hist [$];
    int    mcnt [NI];
    int    passed = 0;
    int    total  = 0;

    task automatic chk(input string nm, input int inst, input logic [511:0] got,
                       input logic [511:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s inst%0d t=%0t got=%0h exp=%0h", nm, inst, $time, got, exp);
    endtask

    task automatic compare_all();
        int n;
        n = hist.size();
        for (int i = 0; i < NI; i++) begin
            int o, q;
            stim_t s;
            logic [6:0]   e_cmd;
            logic [11:0]  e_ctl;
            logic [17:0]  e_ab;
            logic [287:0] e_dout;
            logic         e_vld;
            logic [255:0] e_din;
            logic [31:0]  e_ecc;
            o = n - OSA[i];
            q = n - ISA[i];
            e_cmd = {3'b111, 4'hF};
            e_ctl = {6'b0, 5'b0, 1'b1};
            e_ab = '0; e_dout = '0; e_vld = 1'b0; e_din = '0; e_ecc = '0;
            if (o >= 0) begin
                s = hist[o];
                if (!s.dis) e_cmd = {s.ras_l, s.cas_l, s.we_l, s.cs_l};
                e_ctl = {s.cke, s.clk_en, s.pad_en, s.drv_data & ~s.dis, s.drv_en & ~s.dis,
                         s.pad_inv, s.ptr_inv, s.dis};
                for (int j = o; j >= 0; j--) begin
                    if (!hist[j].dis) begin
                        e_ab = {hist[j].addr, hist[j].bank};
                        e_dout = hist[j].dout;
                        break;
                    end
                end
            end
            if (q >= 0) begin
                e_vld = hist[q].dv;
                for (int j = q; j >= 0; j--) begin
                    if (hist[j].dv) begin
                        e_din = hist[j].din;
                        e_ecc = hist[j].ecc;
                        break;
                    end
                end
            end
            chk("cmd", i, 512'({ras_b[i], cas_b[i], we_b[i], cs_b[i]}), 512'(e_cmd));
            chk("ctl", i, 512'({cke_b[i], clken_b[i], paden_b[i], dd_b[i], de_b[i],
                                padinv_b[i], ptrinv_b[i], dis_b[i]}), 512'(e_ctl));
            chk("addr", i, 512'({addr_b[i], bank_b[i]}), 512'(e_ab));
            chk("dout", i, 512'(dout_b[i]), 512'(e_dout));
            chk("vld", i, 512'(vld_b[i]), 512'(e_vld));
            chk("din", i, 512'(din_b[i]), 512'(e_din));
            chk("ecc", i, 512'(ecc_b[i]), 512'(e_ecc));
            chk("cnt", i, 512'(cnt_b[i]), 512'(mcnt[i]));
        end
    endtask

    task automatic clear_model();
        hist.delete();
        for (int i = 0; i < NI; i++) mcnt[i] = 0;
    endtask

    task automatic cycle();
        stim_t s;
        int n0;
        @(posedge clk);
        if (!arst_l) begin
            clear_model();
        end else begin
            n0 = hist.size();
            for (int i = 0; i < NI; i++) begin
                logic db, vb;
                db = (n0 - OSA[i] >= 0) ? hist[n0 - OSA[i]].dis : 1'b1;
                vb = (n0 - ISA[i] >= 0) ? hist[n0 - ISA[i]].dv : 1'b0;
                if (db) mcnt[i] = 0;
                else if (vb && mcnt[i] < (1 << CWA[i]) - 1) mcnt[i]++;
            end
            s = '{ras_l: ras_l, cas_l: cas_l, we_l: we_l, cke: cke, clk_en: clk_en,
                  pad_en: pad_en, drv_data: drv_data, drv_en: drv_en, pad_inv: pad_inv,
                  dis: dis, dv: dv, cs_l: cs_l, addr: addr, bank: bank, ptr_inv: ptr_inv,
                  dout: dout, din: din, ecc: ecc};
            hist.push_back(s);
        end
        #1;
        compare_all();
    endtask

    task automatic set_idle(input logic d);
        {ras_l, cas_l, we_l} = 3'b111;
        cs_l = 4'hF; addr = '0; bank = '0;
        {cke, clk_en, pad_en, drv_data, drv_en, pad_inv} = 6'b0;
        ptr_inv = '0; dis = d; dout = '0; dv = 1'b0; din = '0; ecc = '0;
    endtask

    task automatic drive_rand();
        {ras_l, cas_l, we_l} = 3'($urandom());
        cs_l = 4'($urandom()); addr = 15'($urandom()); bank = 3'($urandom());
        {cke, clk_en, pad_en, drv_data, drv_en, pad_inv} = 6'($urandom());
        ptr_inv = 5'($urandom());
        if ($urandom_range(0, 9) == 0) dis = ~dis;
        dout = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
        dv = ($urandom_range(0, 9) < 7);
        din = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
        ecc = $urandom();
    endtask

    initial begin
        set_idle(1'b1);
        arst_l = 1'b0;
        clear_model();
        repeat (3) cycle();
        chk("rst_cs", 0, 512'(cs_b[0]), 512'(4'hF));
        chk("rst_strobes", 0, 512'({ras_b[0], cas_b[0], we_b[0]}), 512'(3'b111));
        chk("rst_vld", 0, 512'(vld_b[0]), 512'(1'b0));
        chk("rst_cnt", 0, 512'(cnt_b[0]), 512'(16'h0));
        arst_l = 1'b1;
        set_idle(1'b0);
        repeat (6) cycle();

        // Outbound latency on the three-stage instance.
        addr = 15'h1A5; cs_l = 4'hE; cycle();
        addr = 15'h0;   cs_l = 4'hF; cycle();
        chk("lat_early", 0, 512'({addr_b[0], cs_b[0]}), 512'({15'h0, 4'hF}));
        cycle();
        chk("lat_addr", 0, 512'(addr_b[0]), 512'(15'h1A5));
        chk("lat_cs", 0, 512'(cs_b[0]), 512'(4'hE));
        cycle();
        chk("lat_late", 0, 512'({addr_b[0], cs_b[0]}), 512'({15'h0, 4'hF}));

        // Disable gating.
        addr = 15'h123; cycle();
        dis = 1'b1; cs_l = 4'h0; drv_en = 1'b1; ras_l = 1'b0; addr = 15'h7FFF;
        repeat (3) cycle();
        chk("dis_cs", 0, 512'(cs_b[0]), 512'(4'hF));
        chk("dis_de", 0, 512'(de_b[0]), 512'(1'b0));
        chk("dis_ras", 0, 512'(ras_b[0]), 512'(1'b1));
        chk("dis_addr", 0, 512'(addr_b[0]), 512'(15'h123));
        cycle();
        chk("dis_hold", 0, 512'(addr_b[0]), 512'(15'h123));
        set_idle(1'b0);
        repeat (6) cycle();

        // Read burst with an idle gap.
        dv = 1'b1; din = 256'hA; cycle();
        din = 256'hB; cycle();
        chk("burst0", 0, 512'({vld_b[0], din_b[0]}), 512'({1'b1, 256'hA}));
        dv = 1'b0; din = 256'hC; cycle();
        chk("burst1", 0, 512'({vld_b[0], din_b[0]}), 512'({1'b1, 256'hB}));
        dv = 1'b1; din = 256'hD; cycle();
        chk("burst2", 0, 512'({vld_b[0], din_b[0]}), 512'({1'b0, 256'hB}));
        dv = 1'b0; din = 256'h0; cycle();
        chk("burst3", 0, 512'({vld_b[0], din_b[0]}), 512'({1'b1, 256'hD}));

        // Saturation of the 4-bit counter, then clear beating a coincident valid beat.
        dv = 1'b1;
        repeat (20) cycle();
        chk("cnt_sat", 0, 512'(cnt_b[0]), 512'(16'hF));
        dis = 1'b1;
        repeat (3) cycle();
        chk("cnt_pre_clr", 0, 512'(cnt_b[0]), 512'(16'hF));
        cycle();
        chk("cnt_clr", 0, 512'({vld_b[0], cnt_b[0]}), 512'({1'b1, 16'h0}));

        repeat (300) begin
            drive_rand();
            cycle();
        end

        // Asynchronous reset mid-traffic, checked before any further clock edge.
        drive_rand();
        #2 arst_l = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("arst_cs", i, 512'(cs_b[i]), 512'(4'hF));
            chk("arst_strobes", i, 512'({ras_b[i], cas_b[i], we_b[i]}), 512'(3'b111));
            chk("arst_vld_cnt", i, 512'({vld_b[i], cnt_b[i]}), 512'(17'h0));
        end
        clear_model();
        compare_all();
        repeat (2) cycle();
        arst_l = 1'b1;

        repeat (300) begin
            drive_rand();
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
